elastic_output_pipeline: RTL and testbench
==========================================

# elastic_output_pipeline

Elastic execution back-end of a PE: an ALU stage, an elastic FIFO and an output fork chained with valid/stop handshakes. It sits between the operand join and the neighbour-PE outputs. Its context-switch pulses let the PE advance its per-stage configuration index.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- ADDRESS_WIDTH, 32, memory address width
- NEIGHBOR_PE_NUM, 4, fork output count
- OPERATION_BIT_LENGTH, 4, op field width
- ELASTIC_BUFFER_SIZE_BIT_LENGTH, 2, FIFO depth = 2**this (4)

Ports (x_input = upstream side, x_output = downstream side; stop_input is driven by this block, stop_output is received):
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- input_data_1, input_data_2  in  DATA_WIDTH  joined operands
- op  in  OPERATION_BIT_LENGTH  current ALU context op
- const_data  in  DATA_WIDTH  current context constant
- valid_input  in  1  operand token valid
- stop_input  out  1  backpressure to operand source
- memory_read_address  out  ADDRESS_WIDTH; memory_read_data  in  DATA_WIDTH (asynchronous-read memory)
- memory_write_address  out  ADDRESS_WIDTH; memory_write_data  out  DATA_WIDTH; memory_write  out  1
- available_output  in  NEIGHBOR_PE_NUM  fork destination mask for current context
- output_data[NEIGHBOR_PE_NUM]  out  DATA_WIDTH each; valid_output[NEIGHBOR_PE_NUM]  out  1 each; stop_output[NEIGHBOR_PE_NUM]  in  1 each
- switch_context_alu  out  1  pulse: ALU consumed a token
- switch_context_fork  out  1  pulse: fork completed a token
- debug_data_size  out  ELASTIC_BUFFER_SIZE_BIT_LENGTH+1  FIFO occupancy

## Operation
- Op codes:
  - 0 NOP: result 0
  - 1 ADD: a+b
  - 2 SUB: a-b
  - 3 MUL: low DATA_WIDTH bits of a*b
  - 4 CONST: const_data
  - 5 LOAD: read address = a, result = memory_read_data
  - 6 STORE: write memory[a]=b, no result token
  - 7 ROUTE: a
  - other: treated as NOP
- All arithmetic wraps modulo 2**DATA_WIDTH, unsigned.
- memory_read_address = input_data_1 at all times.
- ALU stage: one output register (data, valid).
  - Accept when valid_input && !stop_input.
  - stop_input = alu_valid && alu_stop, where alu_stop is the FIFO's stop.
  - On accept: switch_context_alu=1 (combinational, same cycle); result registered; alu_valid set except for STORE.
  - STORE accept drives memory_write=1 with address=a and data=b in that same cycle; memory_write is 0 otherwise.
  - If the register is not refilled and the FIFO takes it, alu_valid clears.
- FIFO: depth 2**ELASTIC_BUFFER_SIZE_BIT_LENGTH.
  - stop toward ALU = (count==depth).
  - valid_output = (count!=0); data_output = head.
  - Push and pop in the same cycle keep count unchanged; wrap-around pointers.
  - debug_data_size = count.
- Fork: eager broadcast of the FIFO head to all outputs.
  - valid_output[k] = fifo_valid && available_output[k] && !done[k].
  - A branch is taken when valid_output[k] && !stop_output[k].
  - The token is complete when every enabled k is done or taken this cycle. Then: pop FIFO, clear all done, switch_context_fork=1.
  - Otherwise set done[k] for branches taken this cycle and hold the FIFO.
  - available_output==0 with a valid head: token dropped immediately, switch_context_fork=1.
  - output_data[k] = head for all k.

## Timing
- Reset values:
  - ALU: valid 0, data 0.
  - FIFO: empty, debug_data_size 0.
  - Fork: done all 0.
  - Outputs: valid_output all 0, memory_write 0, switch pulses 0.
- Reset asserted mid-operation discards every in-flight token at once.
- Latency is 2 cycles from ALU accept to valid_output when nothing stalls: ALU register, then FIFO write, then fork is combinational.
- Throughput is 1 token/cycle when there is no backpressure.
- Fork and stop paths are combinational. There is no combinational path from stop_output to stop_input: the FIFO decouples them.
- The mask and op may change after their switch pulse. They must be stable while a token is pending.

## Structure
- Shared package holds:
  - parameters DATA_WIDTH, ADDRESS_WIDTH, NEIGHBOR_PE_NUM, OPERATION_BIT_LENGTH, ELASTIC_BUFFER_SIZE_BIT_LENGTH;
  - op-code enum;
  - elastic wire struct {data, valid, stop}.
- One natural sub-module: elastic_fifo (FIFO with count, valid/stop ports). ALU and fork logic stay in the top.

## Test plan
- ADD a=3,b=4, mask 4'b0011, no stops -> switch_context_alu at cycle 0; valid_output[0],[1]=1 with data 7 at cycle 2, [2],[3]=0; switch_context_fork pulses at cycle 2.
- STORE a=0x10,b=99 -> memory_write=1 with address 0x10, data 99 for one cycle; no output token; debug_data_size stays 0.
- LOAD a=5, memory_read_data=42 -> memory_read_address=5; output token 42.
- Hold stop_output all 1, stream 6 ADD tokens -> FIFO count reaches 4, ALU holds 1, stop_input=1; release stops -> 5 tokens emerge in order.
- Mask 4'b0011, stop_output[1]=1 for 3 cycles -> output 0 fires once and is not repeated; token completes when stop_output[1] drops; switch_context_fork pulses once.
- Mask 0 -> token dropped in one cycle, switch_context_fork=1. Then pulse reset_n low mid-stream -> all valids 0, debug_data_size 0.

Source files
------------

// File: rtl/elastic_output_pipeline_pkg.sv
// Shared definitions for the PE elastic back-end: widths, ALU op codes and the
// elastic handshake bundle.
package elastic_output_pipeline_pkg;

  localparam int DATA_WIDTH                     = 32;
  localparam int ADDRESS_WIDTH                  = 32;
  localparam int NEIGHBOR_PE_NUM                = 4;
  localparam int OPERATION_BIT_LENGTH           = 4;
  localparam int ELASTIC_BUFFER_SIZE_BIT_LENGTH = 2;

  typedef enum logic [OPERATION_BIT_LENGTH-1:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_CONST = 4'd4,
    OP_LOAD  = 4'd5,
    OP_STORE = 4'd6,
    OP_ROUTE = 4'd7
  } op_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  stop;
  } elastic_t;

endpackage

// File: rtl/elastic_output_pipeline_fifo.sv
// Elastic FIFO with valid/stop handshakes on both sides and an occupancy count.
// stop toward the producer depends only on the count, never on stop_output.
module elastic_fifo #(
  parameter int WIDTH     = 32,
  parameter int SIZE_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_input,
  input  logic                 valid_input,
  output logic                 stop_input,
  output logic [WIDTH-1:0]     data_output,
  output logic                 valid_output,
  input  logic                 stop_output,
  output logic [SIZE_BITS:0]   count
);

  localparam int DEPTH = 1 << SIZE_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [SIZE_BITS-1:0] wr_ptr;
  logic [SIZE_BITS-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  assign stop_input   = (count == (SIZE_BITS+1)'(DEPTH));
  assign valid_output = (count != '0);
  assign data_output  = mem[rd_ptr];
  assign push         = valid_input && !stop_input;
  assign pop          = valid_output && !stop_output;

  // NOTE: storage is left unreset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_input;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{SIZE_BITS{1'b0}}, push} - {{SIZE_BITS{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/elastic_output_pipeline.sv
// PE execution back-end: ALU register stage -> elastic FIFO -> eager output fork,
// with context-switch pulses when the ALU consumes and the fork completes a token.
module elastic_output_pipeline #(
  parameter int DATA_WIDTH                     = elastic_output_pipeline_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH                  = elastic_output_pipeline_pkg::ADDRESS_WIDTH,
  parameter int NEIGHBOR_PE_NUM                = elastic_output_pipeline_pkg::NEIGHBOR_PE_NUM,
  parameter int OPERATION_BIT_LENGTH           = elastic_output_pipeline_pkg::OPERATION_BIT_LENGTH,
  parameter int ELASTIC_BUFFER_SIZE_BIT_LENGTH = elastic_output_pipeline_pkg::ELASTIC_BUFFER_SIZE_BIT_LENGTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DATA_WIDTH-1:0]               input_data_1,
  input  logic [DATA_WIDTH-1:0]               input_data_2,
  input  logic [OPERATION_BIT_LENGTH-1:0]     op,
  input  logic [DATA_WIDTH-1:0]               const_data,
  input  logic                                valid_input,
  output logic                                stop_input,
  output logic [ADDRESS_WIDTH-1:0]            memory_read_address,
  input  logic [DATA_WIDTH-1:0]               memory_read_data,
  output logic [ADDRESS_WIDTH-1:0]            memory_write_address,
  output logic [DATA_WIDTH-1:0]               memory_write_data,
  output logic                                memory_write,
  input  logic [NEIGHBOR_PE_NUM-1:0]          available_output,
  output logic [DATA_WIDTH-1:0]               output_data [NEIGHBOR_PE_NUM],
  output logic [NEIGHBOR_PE_NUM-1:0]          valid_output,
  input  logic [NEIGHBOR_PE_NUM-1:0]          stop_output,
  output logic                                switch_context_alu,
  output logic                                switch_context_fork,
  output logic [ELASTIC_BUFFER_SIZE_BIT_LENGTH:0] debug_data_size
);

  import elastic_output_pipeline_pkg::*;

  logic [DATA_WIDTH-1:0]      alu_result;
  logic [DATA_WIDTH-1:0]      alu_data;
  logic                       alu_valid;
  logic                       alu_stop;
  logic                       accept;
  logic [DATA_WIDTH-1:0]      fifo_data;
  logic                       fifo_valid;
  logic                       fork_complete;
  logic [NEIGHBOR_PE_NUM-1:0] done;
  logic [NEIGHBOR_PE_NUM-1:0] taken;

  assign memory_read_address  = ADDRESS_WIDTH'(input_data_1);
  assign memory_write_address = ADDRESS_WIDTH'(input_data_1);
  assign memory_write_data    = input_data_2;

  assign stop_input         = alu_valid && alu_stop;
  assign accept             = valid_input && !stop_input;
  assign switch_context_alu = accept;
  assign memory_write       = accept && (op == OP_STORE);

  always_comb begin
    // NOTE: default first so every path assigns alu_result and no latch is inferred.
    alu_result = '0;
    case (op)
      OP_ADD:   alu_result = input_data_1 + input_data_2;
      OP_SUB:   alu_result = input_data_1 - input_data_2;
      OP_MUL:   alu_result = input_data_1 * input_data_2;
      OP_CONST: alu_result = const_data;
      OP_LOAD:  alu_result = memory_read_data;
      OP_ROUTE: alu_result = input_data_1;
      default:  alu_result = '0;
    endcase
  end

  // A STORE is consumed but produces no downstream token.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_data  <= '0;
      alu_valid <= 1'b0;
    end else if (accept) begin
      alu_data  <= alu_result;
      alu_valid <= (op != OP_STORE);
    end else if (!alu_stop) begin
      alu_valid <= 1'b0;
    end
  end

  elastic_fifo #(
    .WIDTH     (DATA_WIDTH),
    .SIZE_BITS (ELASTIC_BUFFER_SIZE_BIT_LENGTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_input   (alu_data),
    .valid_input  (alu_valid),
    .stop_input   (alu_stop),
    .data_output  (fifo_data),
    .valid_output (fifo_valid),
    .stop_output  (!fork_complete),
    .count        (debug_data_size)
  );

  // Eager fork: each branch fires once per token; an empty mask completes at once.
  assign valid_output  = {NEIGHBOR_PE_NUM{fifo_valid}} & available_output & ~done;
  assign taken         = valid_output & ~stop_output;
  assign fork_complete = fifo_valid && ((available_output & ~(done | taken)) == '0);
  assign switch_context_fork = fork_complete;

  always_comb begin
    for (int k = 0; k < NEIGHBOR_PE_NUM; k++) output_data[k] = fifo_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           done <= '0;
    else if (fork_complete) done <= '0;
    else                    done <= done | taken;
  end

endmodule

// File: tb/tb_elastic_output_pipeline.sv
// Directed self-checking bench for elastic_output_pipeline; inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_elastic_output_pipeline;

  import elastic_output_pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] input_data_1;
  logic [31:0] input_data_2;
  logic [3:0]  op;
  logic [31:0] const_data;
  logic        valid_input;
  logic        stop_input;
  logic [31:0] memory_read_address;
  logic [31:0] memory_read_data;
  logic [31:0] memory_write_address;
  logic [31:0] memory_write_data;
  logic        memory_write;
  logic [3:0]  available_output;
  logic [31:0] output_data [4];
  logic [3:0]  valid_output;
  logic [3:0]  stop_output;
  logic        switch_context_alu;
  logic        switch_context_fork;
  logic [2:0]  debug_data_size;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Asynchronous-read memory model: only address 5 holds a meaningful word.
  assign memory_read_data = (memory_read_address == 32'd5) ? 32'd42 : 32'hDEAD_BEEF;

  elastic_output_pipeline dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .input_data_1         (input_data_1),
    .input_data_2         (input_data_2),
    .op                   (op),
    .const_data           (const_data),
    .valid_input          (valid_input),
    .stop_input           (stop_input),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_write         (memory_write),
    .available_output     (available_output),
    .output_data          (output_data),
    .valid_output         (valid_output),
    .stop_output          (stop_output),
    .switch_context_alu   (switch_context_alu),
    .switch_context_fork  (switch_context_fork),
    .debug_data_size      (debug_data_size)
  );

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; input_data_1 = a; input_data_2 = b; valid_input = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid_input = 1'b0; op = OP_NOP; input_data_1 = '0; input_data_2 = '0;
    const_data = 32'd77; available_output = 4'b0011; stop_output = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (valid_output !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b want 0000", valid_output); end
    n_cmp++; if (debug_data_size !== 3'd0) begin n_err++; $display("FAIL reset_size: got %0d want 0", debug_data_size); end
    n_cmp++; if ({memory_write, switch_context_alu, switch_context_fork, stop_input} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {memory_write, switch_context_alu, switch_context_fork, stop_input}); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk); drive(OP_ADD, 32'd3, 32'd4); #1;
    n_cmp++; if (switch_context_alu !== 1'b1) begin n_err++; $display("FAIL add_switch_alu: got %b want 1", switch_context_alu); end
    n_cmp++; if (memory_write !== 1'b0) begin n_err++; $display("FAIL add_no_write: got %b want 0", memory_write); end
    @(negedge clk); valid_input = 1'b0; #1;
    n_cmp++; if (valid_output !== 4'b0000) begin n_err++; $display("FAIL add_cycle1_valid: got %b want 0000", valid_output); end
    @(negedge clk); #1;
    n_cmp++; if (valid_output !== 4'b0011) begin n_err++; $display("FAIL add_cycle2_valid: got %b want 0011", valid_output); end
    n_cmp++; if (output_data[0] !== 32'd7 || output_data[1] !== 32'd7) begin
      n_err++; $display("FAIL add_data: got %0d/%0d want 7/7", output_data[0], output_data[1]); end
    n_cmp++; if (switch_context_fork !== 1'b1) begin n_err++; $display("FAIL add_switch_fork: got %b want 1", switch_context_fork); end
    @(negedge clk); #1;
    n_cmp++; if (valid_output !== 4'b0000 || debug_data_size !== 3'd0) begin
      n_err++; $display("FAIL add_drained: got valid %b size %0d want 0000/0", valid_output, debug_data_size); end
  endtask

  task automatic test_store();
    @(negedge clk); drive(OP_STORE, 32'h10, 32'd99); #1;
    n_cmp++; if (memory_write !== 1'b1 || memory_write_address !== 32'h10 || memory_write_data !== 32'd99) begin
      n_err++; $display("FAIL store_write: got we %b addr %h data %0d want 1/10/99", memory_write, memory_write_address, memory_write_data); end
    @(negedge clk); valid_input = 1'b0; #1;
    n_cmp++; if (memory_write !== 1'b0) begin n_err++; $display("FAIL store_one_cycle: got %b want 0", memory_write); end
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++; if (valid_output !== 4'b0000 || debug_data_size !== 3'd0) begin
        n_err++; $display("FAIL store_no_token: got valid %b size %0d want 0000/0", valid_output, debug_data_size); end
    end
  endtask

  task automatic test_load();
    @(negedge clk); drive(OP_LOAD, 32'd5, 32'd0); #1;
    n_cmp++; if (memory_read_address !== 32'd5) begin n_err++; $display("FAIL load_addr: got %0d want 5", memory_read_address); end
    @(negedge clk); valid_input = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (valid_output !== 4'b0011 || output_data[0] !== 32'd42) begin
      n_err++; $display("FAIL load_token: got valid %b data %0d want 0011/42", valid_output, output_data[0]); end
  endtask

  task automatic test_backpressure();
    int stalled = 0;
    int waits;
    @(negedge clk); stop_output = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(OP_ADD, 32'd100 + 32'(i), 32'd0); #1;
      waits = 0;
      while (stop_input && waits < 8) begin @(negedge clk); #1; waits++; end
      if (stop_input) stalled++;
    end
    valid_input = 1'b0;
    n_cmp++; if (stalled !== 1) begin n_err++; $display("FAIL bp_stalled_tokens: got %0d want 1", stalled); end
    n_cmp++; if (debug_data_size !== 3'd4) begin n_err++; $display("FAIL bp_fifo_full: got %0d want 4", debug_data_size); end
    n_cmp++; if (stop_input !== 1'b1) begin n_err++; $display("FAIL bp_stop_input: got %b want 1", stop_input); end
    n_cmp++; if (valid_output !== 4'b0011 || output_data[0] !== 32'd100) begin
      n_err++; $display("FAIL bp_head: got valid %b data %0d want 0011/100", valid_output, output_data[0]); end
    @(negedge clk); stop_output = 4'b0000; #1;
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (valid_output !== 4'b0011 || output_data[1] !== 32'd100 + 32'(j)) begin
        n_err++; $display("FAIL bp_drain_%0d: got valid %b data %0d want 0011/%0d", j, valid_output, output_data[1], 100 + j); end
      @(negedge clk); #1;
    end
    n_cmp++; if (valid_output !== 4'b0000 || debug_data_size !== 3'd0 || stop_input !== 1'b0) begin
      n_err++; $display("FAIL bp_empty: got valid %b size %0d stop %b want 0000/0/0", valid_output, debug_data_size, stop_input); end
  endtask

  task automatic test_partial_stop();
    int pulses = 0;
    @(negedge clk); stop_output = 4'b0010; drive(OP_ADD, 32'd1, 32'd1);
    @(negedge clk); valid_input = 1'b0;
    @(negedge clk); #1;
    pulses += int'(switch_context_fork);
    n_cmp++; if (valid_output !== 4'b0011 || output_data[0] !== 32'd2) begin
      n_err++; $display("FAIL part_first: got valid %b data %0d want 0011/2", valid_output, output_data[0]); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      pulses += int'(switch_context_fork);
      n_cmp++; if (valid_output !== 4'b0010) begin n_err++; $display("FAIL part_hold_%0d: got %b want 0010", c, valid_output); end
    end
    @(negedge clk); stop_output = 4'b0000; #1;
    n_cmp++; if (valid_output !== 4'b0010 || switch_context_fork !== 1'b1) begin
      n_err++; $display("FAIL part_release: got valid %b fork %b want 0010/1", valid_output, switch_context_fork); end
    pulses += int'(switch_context_fork);
    @(negedge clk); #1;
    pulses += int'(switch_context_fork);
    n_cmp++; if (valid_output !== 4'b0000 || debug_data_size !== 3'd0) begin
      n_err++; $display("FAIL part_done: got valid %b size %0d want 0000/0", valid_output, debug_data_size); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL part_fork_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_mask_zero();
    @(negedge clk); available_output = 4'b0000; drive(OP_ROUTE, 32'd55, 32'd0);
    @(negedge clk); valid_input = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (valid_output !== 4'b0000 || switch_context_fork !== 1'b1 || debug_data_size !== 3'd1) begin
      n_err++; $display("FAIL mask0_drop: got valid %b fork %b size %0d want 0000/1/1", valid_output, switch_context_fork, debug_data_size); end
    @(negedge clk); #1;
    n_cmp++; if (debug_data_size !== 3'd0 || switch_context_fork !== 1'b0) begin
      n_err++; $display("FAIL mask0_gone: got size %0d fork %b want 0/0", debug_data_size, switch_context_fork); end
    available_output = 4'b0011;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); stop_output = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(OP_SUB, 32'd200 + 32'(i), 32'd1);
    end
    @(negedge clk); valid_input = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (debug_data_size !== 3'd3 || valid_output !== 4'b0011 || output_data[0] !== 32'd199) begin
      n_err++; $display("FAIL midrst_before: got size %0d valid %b data %0d want 3/0011/199", debug_data_size, valid_output, output_data[0]); end
    reset_n = 1'b0; #1;
    n_cmp++; if (valid_output !== 4'b0000 || debug_data_size !== 3'd0 || stop_input !== 1'b0) begin
      n_err++; $display("FAIL midrst_flush: got valid %b size %0d stop %b want 0000/0/0", valid_output, debug_data_size, stop_input); end
    @(negedge clk); reset_n = 1'b1; stop_output = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (valid_output !== 4'b0000 || debug_data_size !== 3'd0) begin
      n_err++; $display("FAIL midrst_after: got valid %b size %0d want 0000/0", valid_output, debug_data_size); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_store();
    test_load();
    test_backpressure();
    test_partial_stop();
    test_mask_zero();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
